// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed wait states, and a
// bench-driven load port that fills the word array sequentially.
module imem_responder #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WAIT  = 2,
   parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        req_valid,
   input  logic [63:0] addr,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_inst,
   output logic        rsp_err,
   input  logic        tb,
   input  logic [31:0] tb_inst
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [63:0] SPAN      = 64'(DEPTH) << 2;
   localparam logic [3:0]  WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Offset is checked only after the lower bound, so the upper compare never wraps.
   function automatic logic addr_err(input logic [63:0] a);
      logic [63:0] off;
      off = a - BASE;
      if (a[1:0] != 2'b00) begin
         return 1'b1;
      end else if (a < BASE) begin
         return 1'b1;
      end else if (off >= SPAN) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   load_ptr_q, load_ptr_d;
   logic [63:0]     addr_q, addr_d;
   logic [31:0]     inst_q, inst_d;
   logic            err_q, err_d;

   logic [31:0]     mem [DEPTH];

   logic            req_ready_s;
   logic            accept_s;
   logic [63:0]     fetch_addr_s;
   logic [AW-1:0]   fetch_idx_s;
   logic            fetch_err_s;
   logic [31:0]     fetch_word_s;

   // With WAIT=0 the word is captured on the accept edge, before addr_q holds it.
   assign fetch_addr_s = (state_q == ST_IDLE) ? addr : addr_q;
   assign fetch_idx_s  = AW'((fetch_addr_s - BASE) >> 2);
   assign fetch_err_s  = addr_err(fetch_addr_s);
   assign fetch_word_s = fetch_err_s ? 32'h0000_0000 : mem[fetch_idx_s];

   assign req_ready_s  = rst & (state_q == ST_IDLE) & ~tb;
   assign accept_s     = ce & req_valid & req_ready_s;

   // Next-state, wait counter and response capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               addr_d = addr;
               if (WAIT == 0) begin
                  state_d = ST_RESP;
                  inst_d  = fetch_word_s;
                  err_d   = fetch_err_s;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               inst_d  = fetch_word_s;
               err_d   = fetch_err_s;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Load pointer advances once per strobed cycle and wraps at DEPTH.
   always_comb begin
      if (tb) begin
         load_ptr_d = load_ptr_q + AW'(1);
      end else begin
         load_ptr_d = load_ptr_q;
      end
   end

   // Control and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         load_ptr_q <= '0;
         addr_q     <= 64'd0;
         inst_q     <= 32'h0000_0000;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         load_ptr_q <= load_ptr_d;
         addr_q     <= addr_d;
         inst_q     <= inst_d;
         err_q      <= err_d;
      end
   end

   // Word array: no reset, so contents survive rst.
   always_ff @(posedge clk) begin
      if (tb && rst) begin
         mem[load_ptr_q] <= tb_inst;
      end
   end

   assign req_ready = req_ready_s;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_inst  = inst_q;
   assign rsp_err   = err_q;

endmodule
